relm_i2c_target: RTL and testbench
==================================

Name: relm_i2c_target

Overview:
- I2C target (responder) for ReLM boards; the other end of the bit-banged I2C controller driven through the push/pop ports.
- Lets the ReLM core act as an I2C peripheral for loopback test against the on-board controller, or for an external host.
- Synchronizes SCL/SDA, detects START/STOP, matches a 7-bit address, ACKs and shifts bytes.
- Exposes a one-byte transmit holding register on a push port and a one-byte receive holding register on a pop port.

Parameters:
WD, 32, ReLM data width; port buses are WD+1 bits, bit WD is the strobe.
ADDR, 7'h2A, own 7-bit target address.
NSYNC, 2, synchronizer flops on scl_in/sda_in (minimum 2).

Ports:
clk  input  1  system clock
rst_n_in  input  1  synchronous active-low reset
scl_in  input  1  SCL from pad (asynchronous)
sda_in  input  1  SDA from pad (asynchronous)
sda_oe_out  output  1  1 = pull SDA low (pad is open-drain, tri-stated otherwise)
push_d_in  input  WD+1  [WD]=write strobe, [7:0]=byte to return on next read
push_retry_out  output  1  1 = tx holding register full; push is ignored
pop_d_in  input  WD+1  [WD]=pop strobe; clears rx_valid and all sticky flags
pop_q_out  output  WD+1  {1'b0, rx_valid, tx_full, stop_seen, start_seen, rd_underrun, rx_overrun, zeros, rx_byte[7:0]}; flags occupy bits WD-1 down to WD-6

Behaviour:
- Reset: applies on the first clk edge with rst_n_in=0; reset mid-transfer abandons the transfer immediately.
  - sda_oe_out=0; state IDLE; holding registers empty; all flags 0; pop_q_out=0; push_retry_out=0.
  - Synchronizer flops reset to 1, so no false edge is seen after reset.
- Synchronization: NSYNC flops per line, plus one extra flop for edge detect.
  - scl_rise/scl_fall, and START = sda falling while scl high, STOP = sda rising while scl high, all computed on the synchronized values.
- START (including repeated START) in any state: go to ADDR, bit count=0, sda_oe_out=0, set start_seen.
- STOP in any state: go to IDLE, sda_oe_out=0, set stop_seen.
- ADDR: shift SDA on each scl_rise, MSB first.
  - After 8 bits, compare [7:1] with ADDR.
  - Mismatch: go to IDLE (ignore bus until next START).
  - Match: on the next scl_fall assert sda_oe_out=1 and enter ADDR_ACK, remembering R/W=bit0.
- ADDR_ACK: release on the following scl_fall.
  - If R/W=0: enter WR_DATA.
  - If R/W=1: enter RD_DATA and drive bit 7 of the tx byte immediately.
  - Tx byte = holding register if full (then mark it empty); otherwise 8'hFF and set rd_underrun.
- WR_DATA: shift 8 bits on scl_rise; on 8th bit complete:
  - If rx_valid=0: load rx_byte, set rx_valid, ACK (sda_oe_out=1 at next scl_fall).
  - If rx_valid=1: NACK (sda_oe_out stays 0), set rx_overrun, keep old byte.
  - WR_ACK releases SDA at the following scl_fall, then returns to WR_DATA.
- RD_DATA: sda_oe_out=~bit, updated only at scl_fall, MSB first.
  - After the 8th scl_fall, release SDA and enter RD_ACK.
- RD_ACK: sample SDA on scl_rise.
  - 0 (controller ACK): at next scl_fall load the next byte (same empty/underrun rule) and drive its bit 7.
  - 1 (NACK): release SDA and go to IDLE.
- SDA from this block changes only one clk after a synchronized scl_fall, never while synchronized scl is high.
- Push handshake: a strobe with push_retry_out=0 loads the byte and sets tx_full the next cycle.
  - Strobe while full is dropped (producer must honour retry).
  - Simultaneous push and internal consume when full: consume first, push loads; tx_full stays 1.
- Pop handshake: pop_q_out is registered and reflects state one cycle after each change.
  - Pop strobe clears rx_valid and all sticky flags.
  - If a byte completes in the same cycle as a pop strobe, the new byte and flag win (rx_valid=1).
- Bit counter is 3 bits and wraps 7->0 at byte end; there is no multi-byte limit.

Test Plan:
- Reset with scl=sda=1 -> sda_oe_out=0, push_retry_out=0, pop_q_out=0; start_seen stays 0 for 10 idle cycles.
- Write to 0x2A with bytes 0x5A, 0xC3; pop between bytes -> ACK on address and both data bytes; pop_q_out[7:0]=0x5A then 0xC3; stop_seen=1 after STOP.
- Write to 0x2B -> no ACK (sda_oe_out never 1); rx_valid=0; start_seen=1.
- Push 0x96, then read from 0x2A with NACK after 1 byte:
  - SDA bits 1,0,0,1,0,1,1,0 observed.
  - push_retry_out 1 to 0 at load into shifter.
  - Block releases on NACK.
- Read 2 bytes with only one pushed -> second byte 0xFF; rd_underrun=1.
- Write two bytes without pop -> second byte NACKed, rx_overrun=1, rx_byte keeps the first.
- Assert rst_n_in mid-read while sda_oe_out=1 -> sda_oe_out=0 next edge; repeated START then restarts cleanly.

Source files
------------

// File: rtl/relm_i2c_target.sv
// relm_i2c_target: 7-bit-address I2C target with a one-byte transmit holding
// register on a ReLM push port and a one-byte receive holding register on a pop port.
module relm_i2c_target #(
    parameter int         WD    = 32,
    parameter logic [6:0] ADDR  = 7'h2A,
    parameter int         NSYNC = 2
) (
    input  logic          clk,
    input  logic          rst_n_in,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe_out,
    input  logic [WD:0]   push_d_in,
    output logic          push_retry_out,
    input  logic [WD:0]   pop_d_in,
    output logic [WD:0]   pop_q_out
);
    localparam int ZW = WD - 14;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_HOLD = 4'd2,
        S_ADDR_ACK  = 4'd3,
        S_WR_DATA   = 4'd4,
        S_WR_HOLD   = 4'd5,
        S_WR_ACK    = 4'd6,
        S_RD_DATA   = 4'd7,
        S_RD_ACK    = 4'd8,
        S_RD_HOLD   = 4'd9
    } state_t;

    logic [NSYNC-1:0] scl_sync_r, sda_sync_r;
    logic             scl_d_r, sda_d_r;
    logic             scl_s, sda_s;
    logic             scl_rise_s, scl_fall_s, start_s, stop_s;

    state_t           state_r, state_nxt_s;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r, tx_sh_r, tx_hold_r, rx_byte_r;
    logic             rw_r, ack_r, sda_oe_r;
    logic             tx_full_r, rx_valid_r;
    logic             start_seen_r, stop_seen_r, rd_underrun_r, rx_overrun_r;
    logic [WD:0]      pop_q_r;

    logic             shift_en_s, cnt_en_s, addr_done_s, byte_done_s, tx_consume_s, oe_nxt_s;
    logic             addr_match_s, push_stb_s, pop_stb_s, push_acc_s;
    logic [7:0]       tx_byte_s;
    logic             unused_bits_s;

    assign scl_s        = scl_sync_r[NSYNC-1];
    assign sda_s        = sda_sync_r[NSYNC-1];
    assign scl_rise_s   = scl_s & ~scl_d_r;
    assign scl_fall_s   = ~scl_s & scl_d_r;
    assign start_s      = scl_s & scl_d_r & sda_d_r & ~sda_s;
    assign stop_s       = scl_s & scl_d_r & ~sda_d_r & sda_s;
    assign addr_match_s = (shift_r[6:0] == ADDR);
    assign tx_byte_s    = tx_full_r ? tx_hold_r : 8'hFF;
    assign push_stb_s   = push_d_in[WD];
    assign pop_stb_s    = pop_d_in[WD];
    // A push is taken when empty, or when full but the shifter consumes in the same cycle.
    assign push_acc_s   = push_stb_s & (~tx_full_r | tx_consume_s);
    assign unused_bits_s = ^{push_d_in[WD-1:8], pop_d_in[WD-1:0]};

    assign sda_oe_out     = sda_oe_r;
    assign push_retry_out = tx_full_r;
    assign pop_q_out      = pop_q_r;

    // Pad synchronizers plus one edge-detect stage; idle-high reset avoids false edges.
    always_ff @(posedge clk) begin
        if (!rst_n_in) begin
            scl_sync_r <= {NSYNC{1'b1}};
            sda_sync_r <= {NSYNC{1'b1}};
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[NSYNC-2:0], scl_in};
            sda_sync_r <= {sda_sync_r[NSYNC-2:0], sda_in};
            scl_d_r    <= scl_s;
            sda_d_r    <= sda_s;
        end
    end

    // Protocol state register.
    always_ff @(posedge clk) begin
        if (!rst_n_in) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; START/STOP override every state.
    always_comb begin
        state_nxt_s = state_r;
        if (start_s) begin
            state_nxt_s = S_ADDR;
        end else if (stop_s) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:      state_nxt_s = S_IDLE;
                S_ADDR:      state_nxt_s = (scl_rise_s && bit_cnt_r == 3'd7) ?
                                           (addr_match_s ? S_ADDR_HOLD : S_IDLE) : S_ADDR;
                S_ADDR_HOLD: state_nxt_s = scl_fall_s ? S_ADDR_ACK : S_ADDR_HOLD;
                S_ADDR_ACK:  state_nxt_s = scl_fall_s ? (rw_r ? S_RD_DATA : S_WR_DATA) : S_ADDR_ACK;
                S_WR_DATA:   state_nxt_s = (scl_rise_s && bit_cnt_r == 3'd7) ? S_WR_HOLD : S_WR_DATA;
                S_WR_HOLD:   state_nxt_s = scl_fall_s ? S_WR_ACK : S_WR_HOLD;
                S_WR_ACK:    state_nxt_s = scl_fall_s ? S_WR_DATA : S_WR_ACK;
                S_RD_DATA:   state_nxt_s = (scl_fall_s && bit_cnt_r == 3'd7) ? S_RD_ACK : S_RD_DATA;
                S_RD_ACK:    state_nxt_s = scl_rise_s ? (sda_s ? S_IDLE : S_RD_HOLD) : S_RD_ACK;
                S_RD_HOLD:   state_nxt_s = scl_fall_s ? S_RD_DATA : S_RD_HOLD;
                default:     state_nxt_s = S_IDLE;
            endcase
        end
    end

    // FSM outputs: datapath strobes and the next SDA pull-down, changed only on scl_fall.
    always_comb begin
        shift_en_s   = scl_rise_s && (state_r == S_ADDR || state_r == S_WR_DATA);
        cnt_en_s     = shift_en_s || (scl_fall_s && state_r == S_RD_DATA);
        addr_done_s  = scl_rise_s && (state_r == S_ADDR) && (bit_cnt_r == 3'd7);
        byte_done_s  = scl_rise_s && (state_r == S_WR_DATA) && (bit_cnt_r == 3'd7);
        tx_consume_s = scl_fall_s && ((state_r == S_ADDR_ACK && rw_r) || state_r == S_RD_HOLD);
        oe_nxt_s     = sda_oe_r;
        if (start_s || stop_s) begin
            oe_nxt_s = 1'b0;
        end else if (scl_fall_s) begin
            case (state_r)
                S_ADDR_HOLD: oe_nxt_s = 1'b1;
                S_ADDR_ACK:  oe_nxt_s = rw_r & ~tx_byte_s[7];
                S_WR_HOLD:   oe_nxt_s = ack_r;
                S_WR_ACK:    oe_nxt_s = 1'b0;
                S_RD_DATA:   oe_nxt_s = (bit_cnt_r == 3'd7) ? 1'b0 : ~tx_sh_r[6];
                S_RD_HOLD:   oe_nxt_s = ~tx_byte_s[7];
                default:     oe_nxt_s = 1'b0;
            endcase
        end else begin
            oe_nxt_s = (state_r == S_IDLE) ? 1'b0 : sda_oe_r;
        end
    end

    // Shifters, bit counter, holding registers, sticky flags and the registered pop view.
    always_ff @(posedge clk) begin
        if (!rst_n_in) begin
            bit_cnt_r     <= 3'd0;
            shift_r       <= 8'h00;
            tx_sh_r       <= 8'h00;
            tx_hold_r     <= 8'h00;
            rx_byte_r     <= 8'h00;
            rw_r          <= 1'b0;
            ack_r         <= 1'b0;
            sda_oe_r      <= 1'b0;
            tx_full_r     <= 1'b0;
            rx_valid_r    <= 1'b0;
            start_seen_r  <= 1'b0;
            stop_seen_r   <= 1'b0;
            rd_underrun_r <= 1'b0;
            rx_overrun_r  <= 1'b0;
            pop_q_r       <= {(WD+1){1'b0}};
        end else begin
            sda_oe_r <= oe_nxt_s;
            if (start_s) begin
                bit_cnt_r <= 3'd0;
            end else if (cnt_en_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            if (shift_en_s) begin
                shift_r <= {shift_r[6:0], sda_s};
            end
            if (addr_done_s) begin
                rw_r <= sda_s;
            end
            if (byte_done_s) begin
                ack_r <= ~rx_valid_r;
            end
            if (tx_consume_s) begin
                tx_sh_r <= tx_byte_s;
            end else if (scl_fall_s && state_r == S_RD_DATA) begin
                tx_sh_r <= {tx_sh_r[6:0], 1'b0};
            end
            if (push_acc_s) begin
                tx_hold_r <= push_d_in[7:0];
                tx_full_r <= 1'b1;
            end else if (tx_consume_s) begin
                tx_full_r <= 1'b0;
            end
            // A byte landing with a pop in the same cycle wins over the clear.
            if (byte_done_s && !rx_valid_r) begin
                rx_byte_r  <= {shift_r[6:0], sda_s};
                rx_valid_r <= 1'b1;
            end else if (pop_stb_s) begin
                rx_valid_r <= 1'b0;
            end
            start_seen_r  <= start_s | (start_seen_r & ~pop_stb_s);
            stop_seen_r   <= stop_s | (stop_seen_r & ~pop_stb_s);
            rd_underrun_r <= (tx_consume_s & ~tx_full_r) | (rd_underrun_r & ~pop_stb_s);
            rx_overrun_r  <= (byte_done_s & rx_valid_r) | (rx_overrun_r & ~pop_stb_s);
            pop_q_r <= {1'b0, rx_valid_r, tx_full_r, stop_seen_r, start_seen_r,
                        rd_underrun_r, rx_overrun_r, {ZW{1'b0}}, rx_byte_r};
        end
    end
endmodule

// File: tb/tb_relm_i2c_target.sv
// Scoreboard bench for relm_i2c_target: a bit-level I2C controller model drives
// the bus, queues expected observations, and a negedge monitor compares them.
module tb_relm_i2c_target;
    localparam int WD = 32;
    localparam int Q  = 8;
    localparam int K_OE = 0, K_RETRY = 1, K_POPQ = 2, K_BYTE = 3, K_FLAG = 4, K_SEEN = 5, K_SDA = 6;
    localparam int F_RXV = WD-1, F_TXF = WD-2, F_STOP = WD-3, F_START = WD-4, F_UND = WD-5, F_OVR = WD-6;

    typedef struct {
        int          kind;
        int          idx;
        logic [WD:0] exp;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n_in;
    logic        scl_tb, sda_tb;
    wire         scl_in, sda_in;
    logic        sda_oe_out;
    logic [WD:0] push_d_in;
    logic        push_retry_out;
    logic [WD:0] pop_d_in;
    logic [WD:0] pop_q_out;
    logic        oe_seen, seen_clr;

    exp_t exp_q[$];
    int   applied = 0;
    int   miscompares = 0;

    assign scl_in = scl_tb;
    assign sda_in = sda_tb & ~sda_oe_out;

    relm_i2c_target #(.WD(WD), .ADDR(7'h2A), .NSYNC(2)) dut (
        .clk(clk), .rst_n_in(rst_n_in), .scl_in(scl_in), .sda_in(sda_in),
        .sda_oe_out(sda_oe_out), .push_d_in(push_d_in), .push_retry_out(push_retry_out),
        .pop_d_in(pop_d_in), .pop_q_out(pop_q_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (seen_clr) oe_seen <= 1'b0;
        else if (sda_oe_out) oe_seen <= 1'b1;
    end

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [WD:0] act;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_OE:    act = {{WD{1'b0}}, sda_oe_out};
                K_RETRY: act = {{WD{1'b0}}, push_retry_out};
                K_POPQ:  act = pop_q_out;
                K_BYTE:  act = {{(WD-7){1'b0}}, pop_q_out[7:0]};
                K_FLAG:  act = {{WD{1'b0}}, pop_q_out[e.idx]};
                K_SEEN:  act = {{WD{1'b0}}, oe_seen};
                K_SDA:   act = {{WD{1'b0}}, sda_in};
                default: act = {(WD+1){1'b1}};
            endcase
            applied++;
            if (act !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", e.name, act, e.exp, $time);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [WD:0] b1(input logic v);
        return {{WD{1'b0}}, v};
    endfunction

    function automatic logic [WD:0] z8(input logic [7:0] v);
        return {{(WD-7){1'b0}}, v};
    endfunction

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input int kind, input int idx, input logic [WD:0] e, input string name);
        exp_t item;
        item.kind = kind;
        item.idx  = idx;
        item.exp  = e;
        item.name = name;
        exp_q.push_back(item);
    endtask

    task automatic i2c_start();
        sda_tb = 1'b1; wt(Q);
        scl_tb = 1'b1; wt(Q);
        sda_tb = 1'b0; wt(Q);
        scl_tb = 1'b0; wt(Q);
    endtask

    task automatic i2c_stop();
        sda_tb = 1'b0; wt(Q);
        scl_tb = 1'b1; wt(Q);
        sda_tb = 1'b1; wt(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic ack, input string name);
        for (int i = 7; i >= 0; i--) begin
            sda_tb = b[i]; wt(Q);
            scl_tb = 1'b1; wt(2*Q);
            scl_tb = 1'b0; wt(Q);
        end
        sda_tb = 1'b1; wt(Q);
        scl_tb = 1'b1; wt(Q);
        chk(K_OE, 0, b1(ack), name);
        wt(Q);
        scl_tb = 1'b0; wt(Q);
    endtask

    task automatic read_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_tb = 1'b1; wt(Q);
            scl_tb = 1'b1; wt(Q);
            chk(K_SDA, 0, b1(b[i]), "rd_bit");
            wt(Q);
            scl_tb = 1'b0; wt(Q);
        end
        sda_tb = ~ack; wt(Q);
        scl_tb = 1'b1; wt(Q);
        chk(K_OE, 0, b1(1'b0), "rd_ack_release");
        wt(Q);
        scl_tb = 1'b0; wt(Q);
    endtask

    task automatic do_push(input logic [7:0] b);
        push_d_in = {1'b1, {(WD-8){1'b0}}, b}; wt(1);
        push_d_in = {(WD+1){1'b0}}; wt(2);
    endtask

    task automatic do_pop();
        pop_d_in = {1'b1, {WD{1'b0}}}; wt(1);
        pop_d_in = {(WD+1){1'b0}}; wt(2);
    endtask

    initial begin
        rst_n_in  = 1'b0;
        scl_tb    = 1'b1;
        sda_tb    = 1'b1;
        push_d_in = {(WD+1){1'b0}};
        pop_d_in  = {(WD+1){1'b0}};
        seen_clr  = 1'b1;

        // Reset state and quiet idle bus
        wt(3);
        chk(K_OE, 0, b1(1'b0), "reset_oe");
        chk(K_RETRY, 0, b1(1'b0), "reset_retry");
        chk(K_POPQ, 0, {(WD+1){1'b0}}, "reset_popq");
        wt(1);
        rst_n_in = 1'b1;
        seen_clr = 1'b0;
        wt(10);
        chk(K_POPQ, 0, {(WD+1){1'b0}}, "idle_popq");
        chk(K_FLAG, F_START, b1(1'b0), "idle_start_seen");
        wt(1);

        // Write 0x5A, 0xC3 to 0x2A with a pop between bytes
        i2c_start();
        write_byte(8'h54, 1'b1, "wr_addr_ack");
        write_byte(8'h5A, 1'b1, "wr_d0_ack");
        chk(K_BYTE, 0, z8(8'h5A), "wr_d0_byte");
        chk(K_FLAG, F_RXV, b1(1'b1), "wr_d0_rxv");
        chk(K_FLAG, F_START, b1(1'b1), "wr_start_seen");
        wt(1);
        do_pop();
        chk(K_FLAG, F_RXV, b1(1'b0), "pop_clr_rxv");
        chk(K_FLAG, F_START, b1(1'b0), "pop_clr_start");
        wt(1);
        write_byte(8'hC3, 1'b1, "wr_d1_ack");
        chk(K_BYTE, 0, z8(8'hC3), "wr_d1_byte");
        i2c_stop();
        chk(K_FLAG, F_STOP, b1(1'b1), "wr_stop_seen");
        wt(1);
        do_pop();
        chk(K_POPQ, 0, z8(8'hC3), "pop_after_wr");
        wt(1);

        // Wrong address is ignored
        seen_clr = 1'b1; wt(1); seen_clr = 1'b0;
        i2c_start();
        write_byte(8'h56, 1'b0, "badaddr_nack");
        i2c_stop();
        chk(K_SEEN, 0, b1(1'b0), "badaddr_oe_never");
        chk(K_FLAG, F_RXV, b1(1'b0), "badaddr_rxv");
        chk(K_FLAG, F_START, b1(1'b1), "badaddr_start_seen");
        wt(1);
        do_pop();

        // Read one pushed byte, controller NACKs
        do_push(8'h96);
        chk(K_RETRY, 0, b1(1'b1), "push_retry_full");
        chk(K_FLAG, F_TXF, b1(1'b1), "push_tx_full");
        wt(1);
        i2c_start();
        write_byte(8'h55, 1'b1, "rd_addr_ack");
        chk(K_RETRY, 0, b1(1'b0), "retry_after_load");
        wt(1);
        read_byte(8'h96, 1'b0);
        chk(K_OE, 0, b1(1'b0), "rd_nack_release");
        wt(2*Q);
        chk(K_OE, 0, b1(1'b0), "rd_nack_idle");
        i2c_stop();
        chk(K_FLAG, F_UND, b1(1'b0), "rd_no_underrun");
        wt(1);
        do_pop();

        // Two-byte read with one byte pushed -> 0xFF and underrun
        do_push(8'hA5);
        i2c_start();
        write_byte(8'h55, 1'b1, "rd2_addr_ack");
        read_byte(8'hA5, 1'b1);
        read_byte(8'hFF, 1'b0);
        i2c_stop();
        chk(K_FLAG, F_UND, b1(1'b1), "rd2_underrun");
        chk(K_RETRY, 0, b1(1'b0), "rd2_retry");
        wt(1);
        do_pop();

        // Two writes without pop -> second NACKed, overrun, first byte kept
        i2c_start();
        write_byte(8'h54, 1'b1, "ovr_addr_ack");
        write_byte(8'h11, 1'b1, "ovr_d0_ack");
        write_byte(8'h22, 1'b0, "ovr_d1_nack");
        i2c_stop();
        chk(K_FLAG, F_OVR, b1(1'b1), "ovr_flag");
        chk(K_BYTE, 0, z8(8'h11), "ovr_keep_byte");
        chk(K_FLAG, F_RXV, b1(1'b1), "ovr_rxv");
        wt(1);
        do_pop();

        // Reset while driving SDA low mid-read, then repeated START
        do_push(8'h00);
        i2c_start();
        write_byte(8'h55, 1'b1, "rst_addr_ack");
        sda_tb = 1'b1; wt(Q);
        scl_tb = 1'b1; wt(Q);
        chk(K_OE, 0, b1(1'b1), "rst_pre_drive");
        wt(1);
        rst_n_in = 1'b0; wt(1);
        rst_n_in = 1'b1;
        chk(K_OE, 0, b1(1'b0), "rst_mid_oe");
        chk(K_POPQ, 0, {(WD+1){1'b0}}, "rst_mid_popq");
        wt(Q);
        i2c_start();
        write_byte(8'h54, 1'b1, "restart_addr_ack");
        write_byte(8'h3C, 1'b1, "restart_d_ack");
        i2c_stop();
        chk(K_BYTE, 0, z8(8'h3C), "restart_byte");
        chk(K_FLAG, F_RXV, b1(1'b1), "restart_rxv");
        chk(K_FLAG, F_START, b1(1'b1), "restart_start_seen");
        chk(K_FLAG, F_UND, b1(1'b0), "restart_underrun");
        wt(4);

        if (sda_oe_out !== 1'b0) begin
            miscompares++;
            $display("FAIL final_oe: sda_oe_out not released at end of test");
        end
        if (applied < 12) begin
            miscompares++;
            $display("FAIL vector_count: only %0d vectors applied", applied);
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        if (miscompares != 0) begin
            $display("FAIL: %0d miscompares", miscompares);
        end else begin
            $display("PASS");
        end
        $finish;
    end
endmodule
